// File: rtl/beep_sequencer.sv
// Fixed-priority buzzer arbiter: serves one of three requesters with a burst of
// 1..4 square-wave tone pulses, then holds a silent gap before the next burst.
module beep_sequencer #(
    parameter int TONE_HALF = 12500,
    parameter int ON_CYC    = 5000000,
    parameter int OFF_CYC   = 5000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [2:0] req,
    input  logic [5:0] req_cnt,
    input  logic       mute,
    output logic       beep,
    output logic [2:0] grant,
    output logic       busy,
    output logic       done
);

    localparam int TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int ON_W   = (ON_CYC > 1) ? $clog2(ON_CYC) : 1;
    localparam int OFF_W  = (OFF_CYC > 1) ? $clog2(OFF_CYC) : 1;

    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
    localparam logic [ON_W-1:0]   ON_LAST   = ON_W'(ON_CYC - 1);
    localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(OFF_CYC - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    state_t            state, state_n;
    logic [ON_W-1:0]   on_cnt, on_cnt_n;
    logic [OFF_W-1:0]  off_cnt, off_cnt_n;
    logic [TONE_W-1:0] tone_cnt, tone_cnt_n;
    logic              phase, phase_n;
    logic [2:0]        remaining, remaining_n;
    logic [2:0]        pending, pending_n;
    logic [5:0]        cnt_lat, cnt_lat_n;
    logic [2:0]        pick, take;
    logic [1:0]        pick_cnt;
    logic [2:0]        grant_n;
    logic              beep_n, busy_n, done_n;

    // Highest-index pending requester wins
    always_comb begin
        pick     = 3'b000;
        pick_cnt = 2'd0;
        if (pending[2]) begin
            pick     = 3'b100;
            pick_cnt = cnt_lat[5:4];
        end else if (pending[1]) begin
            pick     = 3'b010;
            pick_cnt = cnt_lat[3:2];
        end else if (pending[0]) begin
            pick     = 3'b001;
            pick_cnt = cnt_lat[1:0];
        end
    end

    assign take = (state == IDLE && !mute) ? pick : 3'b000;

    // A request in the grant cycle re-arms its pending bit for a later burst
    always_comb begin
        pending_n = pending & ~take;
        cnt_lat_n = cnt_lat;
        for (int i = 0; i < 3; i++) begin
            if (req[i]) begin
                pending_n[i]       = 1'b1;
                cnt_lat_n[2*i +: 2] = req_cnt[2*i +: 2];
            end
        end
        if (mute) begin
            pending_n = 3'b000;
            cnt_lat_n = cnt_lat;
        end
    end

    always_comb begin
        state_n     = state;
        on_cnt_n    = on_cnt;
        off_cnt_n   = off_cnt;
        tone_cnt_n  = tone_cnt;
        phase_n     = phase;
        remaining_n = remaining;
        grant_n     = grant;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                if (pick != 3'b000) begin
                    state_n     = ON;
                    grant_n     = pick;
                    remaining_n = {1'b0, pick_cnt} + 3'd1;
                    on_cnt_n    = '0;
                    tone_cnt_n  = '0;
                    phase_n     = 1'b1;
                end
            end
            ON: begin
                if (on_cnt == ON_LAST) begin
                    on_cnt_n    = '0;
                    off_cnt_n   = '0;
                    tone_cnt_n  = '0;
                    phase_n     = 1'b0;
                    remaining_n = remaining - 3'd1;
                    state_n     = (remaining_n != 3'd0) ? OFF : GAP;
                end else begin
                    on_cnt_n = on_cnt + ON_W'(1);
                    if (tone_cnt == TONE_LAST) begin
                        tone_cnt_n = '0;
                        phase_n    = ~phase;
                    end else begin
                        tone_cnt_n = tone_cnt + TONE_W'(1);
                    end
                end
            end
            OFF: begin
                if (off_cnt == OFF_LAST) begin
                    state_n    = ON;
                    off_cnt_n  = '0;
                    on_cnt_n   = '0;
                    tone_cnt_n = '0;
                    phase_n    = 1'b1;
                end else begin
                    off_cnt_n = off_cnt + OFF_W'(1);
                end
            end
            GAP: begin
                if (off_cnt == OFF_LAST) begin
                    state_n   = IDLE;
                    off_cnt_n = '0;
                    grant_n   = 3'b000;
                    done_n    = 1'b1;
                end else begin
                    off_cnt_n = off_cnt + OFF_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        // Abort: drop the burst silently, no completion pulse
        if (mute) begin
            state_n     = IDLE;
            on_cnt_n    = '0;
            off_cnt_n   = '0;
            tone_cnt_n  = '0;
            phase_n     = 1'b0;
            remaining_n = 3'd0;
            grant_n     = 3'b000;
            done_n      = 1'b0;
        end
        beep_n = (state_n == ON) && phase_n;
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            on_cnt    <= '0;
            off_cnt   <= '0;
            tone_cnt  <= '0;
            phase     <= 1'b0;
            remaining <= 3'd0;
            pending   <= 3'b000;
            cnt_lat   <= 6'd0;
            grant     <= 3'b000;
            beep      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            on_cnt    <= on_cnt_n;
            off_cnt   <= off_cnt_n;
            tone_cnt  <= tone_cnt_n;
            phase     <= phase_n;
            remaining <= remaining_n;
            pending   <= pending_n;
            cnt_lat   <= cnt_lat_n;
            grant     <= grant_n;
            beep      <= beep_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer with short timing parameters; each burst is
// compared cycle by cycle against a small timing model of grant/busy/beep/done.
module tb_beep_sequencer;

    localparam int TH   = 2;
    localparam int ONC  = 8;
    localparam int OFFC = 4;
    localparam int PER  = ONC + OFFC;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [2:0] req     = 3'b000;
    logic [5:0] req_cnt = 6'd0;
    logic       mute    = 1'b0;
    logic       beep;
    logic [2:0] grant;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    logic [5:0] obs, exp_v;

    beep_sequencer #(.TONE_HALF(TH), .ON_CYC(ONC), .OFF_CYC(OFFC)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (req),
        .req_cnt (req_cnt),
        .mute    (mute),
        .beep    (beep),
        .grant   (grant),
        .busy    (busy),
        .done    (done)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {grant, busy, beep, done} at cycle t after the grant edge of an n-pulse burst
    function automatic logic [5:0] exp_out(input logic [2:0] g, input int n, input int t);
        int pos;
        int win;
        logic bp;
        if (t < PER * n) begin
            pos = t % PER;
            win = t / PER;
            bp  = (win < n) && (pos < ONC) && (((pos / TH) % 2) == 0);
            return {g, 1'b1, bp, 1'b0};
        end else if (t == PER * n) begin
            return 6'b000_0_0_1;
        end
        return 6'd0;
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        step();
        step();
        obs = {grant, busy, beep, done};
        checks++;
        if (obs !== 6'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp %b", obs, 6'd0);
        end
        checks++;
        if (dut.pending !== 3'b000) begin
            errors++;
            $display("FAIL reset_pending got %b exp 000", dut.pending);
        end
        sys_rst = 1'b0;
        step();
        obs = {grant, busy, beep, done};
        checks++;
        if (obs !== 6'd0) begin
            errors++;
            $display("FAIL idle_after_reset got %b exp %b", obs, 6'd0);
        end
    endtask

    task automatic test_single();
        req = 3'b001;
        req_cnt = 6'd0;
        step();
        req = 3'b000;
        obs = {grant, busy, beep, done};
        checks++;
        if (obs !== 6'd0 || dut.pending !== 3'b001) begin
            errors++;
            $display("FAIL single_latency got out=%b pend=%b exp out=000000 pend=001", obs, dut.pending);
        end
        step();
        for (int t = 0; t <= PER; t++) begin
            obs = {grant, busy, beep, done};
            exp_v = exp_out(3'b001, 1, t);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL single t=%0d got %b exp %b", t, obs, exp_v);
            end
            step();
        end
    endtask

    task automatic test_multi();
        req = 3'b010;
        req_cnt = 6'b00_10_00;
        step();
        req = 3'b000;
        obs = {grant, busy, beep, done};
        checks++;
        if (obs !== 6'd0) begin
            errors++;
            $display("FAIL multi_latency got %b exp %b", obs, 6'd0);
        end
        step();
        for (int t = 0; t <= 3 * PER; t++) begin
            obs = {grant, busy, beep, done};
            exp_v = exp_out(3'b010, 3, t);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL multi t=%0d got %b exp %b", t, obs, exp_v);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        req = 3'b101;
        req_cnt = 6'd0;
        step();
        req = 3'b000;
        step();
        for (int t = 0; t <= PER; t++) begin
            obs = {grant, busy, beep, done};
            exp_v = exp_out(3'b100, 1, t);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL b2b_first t=%0d got %b exp %b", t, obs, exp_v);
            end
            step();
        end
        for (int t = 0; t <= PER; t++) begin
            obs = {grant, busy, beep, done};
            exp_v = exp_out(3'b001, 1, t);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL b2b_second t=%0d got %b exp %b", t, obs, exp_v);
            end
            step();
        end
    endtask

    task automatic test_mid_burst();
        req = 3'b100;
        req_cnt = 6'd0;
        step();
        req = 3'b000;
        step();
        for (int t = 0; t <= PER; t++) begin
            obs = {grant, busy, beep, done};
            exp_v = exp_out(3'b100, 1, t);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL mid_burst_hi t=%0d got %b exp %b", t, obs, exp_v);
            end
            req = (t == 3) ? 3'b001 : 3'b000;
            step();
        end
        for (int t = 0; t <= PER; t++) begin
            obs = {grant, busy, beep, done};
            exp_v = exp_out(3'b001, 1, t);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL mid_burst_lo t=%0d got %b exp %b", t, obs, exp_v);
            end
            step();
        end
    endtask

    task automatic test_mute();
        req = 3'b010;
        req_cnt = 6'd0;
        step();
        req = 3'b000;
        step();
        for (int t = 0; t < 5; t++) begin
            obs = {grant, busy, beep, done};
            exp_v = exp_out(3'b010, 1, t);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL mute_pre t=%0d got %b exp %b", t, obs, exp_v);
            end
            if (t == 4) mute = 1'b1;
            step();
        end
        obs = {grant, busy, beep, done};
        checks++;
        if (obs !== 6'd0) begin
            errors++;
            $display("FAIL mute_abort got %b exp %b", obs, 6'd0);
        end
        req = 3'b100;
        step();
        req = 3'b000;
        mute = 1'b0;
        checks++;
        if (dut.pending !== 3'b000) begin
            errors++;
            $display("FAIL mute_req_ignored pending got %b exp 000", dut.pending);
        end
        for (int t = 0; t < 20; t++) begin
            obs = {grant, busy, beep, done};
            checks++;
            if (obs !== 6'd0) begin
                errors++;
                $display("FAIL mute_quiet t=%0d got %b exp %b", t, obs, 6'd0);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        req = 3'b100;
        req_cnt = 6'b11_00_00;
        step();
        req = 3'b000;
        step();
        for (int t = 0; t < 10; t++) begin
            obs = {grant, busy, beep, done};
            exp_v = exp_out(3'b100, 4, t);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rst_mid_pre t=%0d got %b exp %b", t, obs, exp_v);
            end
            req = (t == 2) ? 3'b001 : 3'b000;
            if (t == 9) sys_rst = 1'b1;
            step();
        end
        obs = {grant, busy, beep, done};
        checks++;
        if (obs !== 6'd0 || dut.pending !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_clear got out=%b pend=%b exp out=000000 pend=000", obs, dut.pending);
        end
        sys_rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            step();
            obs = {grant, busy, beep, done};
            checks++;
            if (obs !== 6'd0) begin
                errors++;
                $display("FAIL rst_mid_idle t=%0d got %b exp %b", t, obs, 6'd0);
            end
        end
        req = 3'b001;
        req_cnt = 6'd0;
        step();
        req = 3'b000;
        obs = {grant, busy, beep, done};
        checks++;
        if (obs !== 6'd0) begin
            errors++;
            $display("FAIL rst_fresh_latency got %b exp %b", obs, 6'd0);
        end
        step();
        for (int t = 0; t <= PER; t++) begin
            obs = {grant, busy, beep, done};
            exp_v = exp_out(3'b001, 1, t);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rst_fresh t=%0d got %b exp %b", t, obs, exp_v);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_back_to_back();
        test_mid_burst();
        test_mute();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
